// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
//   state_e   : controller state encoding (IDLE/RUN/DONE)
//   STATE_W   : width of the state register
//   cnt_width : bit-counter width able to hold 0..w
package serial_add_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must reach w itself (it increments past the MSB index).
    function automatic int unsigned cnt_width(input int unsigned w);
        return int'($clog2(w + 1));
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, used as the bit-slice datapath.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused over WIDTH cycles, LSB first.
//   clk, rst                : clock, asynchronous active-high reset
//   start_valid/start_ready : job handshake; a_in/b_in/cin_in sampled on acceptance
//   done_valid/done_ready   : result handshake; sum_out/cout_out/ovf_out held while stalled
//   busy                    : job in flight or result pending
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_shift;

    // Bit-slice datapath: always looks at the current LSBs and the carry flop.
    full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at index 0.
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = RUN;
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            RUN: begin
                res_d   = res_shift;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                // Carry produced by bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_W'(WIDTH - 2)) begin
                    c_msb_d = fa_co;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = res_shift;
                    cout_d  = fa_co;
                    ovf_d   = fa_co ^ c_msb_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode straight from the state register.
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done_valid  = (state_q == DONE);
    assign sum_out     = sum_q;
    assign cout_out    = cout_q;
    assign ovf_out     = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=8).
module tb_serial_add_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;
    logic         busy;

    int tests = 0;
    int fails = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin_in      (cin_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum_out     (sum_out),
        .cout_out    (cout_out),
        .ovf_out     (ovf_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a job at a falling edge; returns just after the accepting edge.
    task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        a_in        = a;
        b_in        = b;
        cin_in      = c;
        start_valid = 1'b1;
        chk("start_ready_idle", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        // Operands changing after acceptance must not affect the job.
        a_in   = ~a;
        b_in   = ~b;
        cin_in = ~c;
        chk("busy_run", 32'(busy), 32'd1);
        chk("start_ready_run", 32'(start_ready), 32'd0);
    endtask

    // Wait (bounded) for the result, check latency and values.
    task automatic wait_check(input string tag, input logic [W-1:0] s, input logic co, input logic ov);
        int n;
        n = 0;
        while (done_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(sum_out), 32'(s));
        chk({tag, "_cout"}, 32'(cout_out), 32'(co));
        chk({tag, "_ovf"}, 32'(ovf_out), 32'(ov));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("idle_after_release", {29'd0, start_ready, done_valid, busy}, 32'b100);
    endtask

    initial begin
        int quiet;
        rst         = 1'b1;
        start_valid = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin_in      = 1'b0;
        done_ready  = 1'b0;
        #1;
        chk("reset_flags", {29'd0, start_ready, done_valid, busy}, 32'b100);
        chk("reset_outs", {22'd0, sum_out, cout_out, ovf_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        start_job(8'h0F, 8'h01, 1'b0);
        wait_check("basic", 8'h10, 1'b0, 1'b0);
        release_done();

        start_job(8'h7F, 8'h01, 1'b0);
        wait_check("sovf_pos", 8'h80, 1'b0, 1'b1);
        release_done();

        // Reset three RUN edges into a job.
        start_job(8'hAA, 8'h55, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_flags", {29'd0, start_ready, done_valid, busy}, 32'b100);
        chk("midrst_outs", {22'd0, sum_out, cout_out, ovf_out}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_valid !== 1'b0) quiet++;
        end
        chk("midrst_no_done", 32'(quiet), 32'd0);

        start_job(8'h12, 8'h34, 1'b0);
        wait_check("after_rst", 8'h46, 1'b0, 1'b0);
        release_done();

        start_job(8'hFF, 8'h01, 1'b0);
        wait_check("uwrap", 8'h00, 1'b1, 1'b0);
        release_done();

        start_job(8'h80, 8'h80, 1'b0);
        wait_check("sovf_neg", 8'h00, 1'b1, 1'b1);
        release_done();

        start_job(8'h00, 8'h00, 1'b1);
        wait_check("cin_only", 8'h01, 1'b0, 1'b0);
        release_done();

        start_job(8'hFF, 8'h00, 1'b1);
        wait_check("cin_wrap", 8'h00, 1'b1, 1'b0);
        release_done();

        // Back-pressure with a competing start request held high.
        start_job(8'h55, 8'h22, 1'b0);
        wait_check("bp", 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            a_in        = W'(8'hA0 + i);
            b_in        = 8'h11;
            cin_in      = 1'b1;
            chk("bp_hold_sum", 32'(sum_out), 32'h77);
            chk("bp_hold_flags", {29'd0, start_ready, done_valid, busy}, 32'b011);
        end
        @(negedge clk);
        a_in       = 8'h3C;
        b_in       = 8'hC4;
        cin_in     = 1'b0;
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("bp_idle", {29'd0, start_ready, done_valid, busy}, 32'b100);
        @(negedge clk);
        start_valid = 1'b0;
        chk("bp_accept", 32'(busy), 32'd1);
        wait_check("bp_next", 8'h00, 1'b1, 1'b0);
        release_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
